// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per hz100 cycle.
// Results, digit blanking enables and overflow flag are valid together with done.
module bin_to_bcd_seq #(
  parameter int WIDTH = 32,
  parameter int NDIG  = 10,
  parameter int NDISP = 8
) (
  input  logic               hz100,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   bin_in,
  output logic               busy,
  output logic               done,
  output logic [4*NDIG-1:0]  bcd_out,
  output logic [NDISP-1:0]   digit_en,
  output logic               ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]  sreg;
  logic [4*NDIG-1:0] scratch;
  logic [CW-1:0]     cnt;

  logic load;
  logic shift_en;
  logic last;

  logic [4*NDIG-1:0] adj;
  logic [4*NDIG-1:0] scratch_sh;
  logic [WIDTH-1:0]  sreg_sh;

  logic [NDIG-1:0]   nz;
  logic [NDIG-1:0]   lead;
  logic              any_nz;
  logic [NDISP-1:0]  en_nxt;
  logic              ovf_nxt;

  // State register
  always_ff @(posedge hz100) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        if (cnt == CW'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign last = shift_en && (cnt == CW'(1));

  // Add-3 correction on every digit that would overflow past 9 when doubled
  always_comb begin
    adj = scratch;
    for (int i = 0; i < NDIG; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  assign scratch_sh = {adj[4*NDIG-2:0], sreg[WIDTH-1]};
  assign sreg_sh    = {sreg[WIDTH-2:0], 1'b0};

  // Blanking and overflow are derived from the value about to be captured
  always_comb begin
    nz      = '0;
    lead    = '0;
    any_nz  = 1'b0;
    en_nxt  = '0;
    ovf_nxt = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      nz[i] = |scratch_sh[4*i +: 4];
    end
    for (int i = NDIG - 1; i >= 0; i--) begin
      any_nz  = any_nz | nz[i];
      lead[i] = any_nz;
    end
    for (int i = 0; i < NDISP; i++) begin
      en_nxt[i] = lead[i];
    end
    en_nxt[0] = 1'b1;
    for (int i = NDISP; i < NDIG; i++) begin
      ovf_nxt = ovf_nxt | nz[i];
    end
  end

  // Datapath: operand shift register, BCD scratch, bit counter, output registers
  always_ff @(posedge hz100) begin
    if (!reset) begin
      sreg     <= '0;
      scratch  <= '0;
      cnt      <= '0;
      bcd_out  <= '0;
      digit_en <= NDISP'(1);
      ovf      <= 1'b0;
    end else begin
      if (load) begin
        sreg    <= bin_in;
        scratch <= '0;
        cnt     <= CW'(WIDTH);
      end else if (shift_en) begin
        sreg    <= sreg_sh;
        scratch <= scratch_sh;
        cnt     <= cnt - CW'(1);
      end
      if (last) begin
        bcd_out  <= scratch_sh;
        digit_en <= en_nxt;
        ovf      <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: conversion values, latency, start filtering,
// reset abort and back-to-back throughput.
module tb_bin_to_bcd_seq;

  logic        hz100;
  logic        reset;
  logic        start;
  logic [31:0] bin_in;
  logic        busy;
  logic        done;
  logic [39:0] bcd_out;
  logic [7:0]  digit_en;
  logic        ovf;

  int vectors;
  int miscompares;

  bin_to_bcd_seq #(.WIDTH(32), .NDIG(10), .NDISP(8)) dut (
    .hz100    (hz100),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .digit_en (digit_en),
    .ovf      (ovf)
  );

  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  // Advance one cycle; outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge hz100);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    start  = 1'b1;
    bin_in = 32'd77;
    tick();
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (bcd_out !== 40'h0) begin miscompares++; $display("FAIL reset_bcd: got %h expected 0", bcd_out); end
    vectors++; if (digit_en !== 8'h01) begin miscompares++; $display("FAIL reset_en: got %b expected 00000001", digit_en); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    start = 1'b0;
    reset = 1'b1;
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_conversions();
    logic [31:0] vin   [6];
    logic [39:0] vbcd  [6];
    logic [7:0]  ven   [6];
    logic        vovf  [6];
    int lat;
    vin[0] = 32'd0;          vbcd[0] = 40'h0000000000; ven[0] = 8'h01; vovf[0] = 1'b0;
    vin[1] = 32'd12345;      vbcd[1] = 40'h0000012345; ven[1] = 8'h1F; vovf[1] = 1'b0;
    vin[2] = 32'd99999999;   vbcd[2] = 40'h0099999999; ven[2] = 8'hFF; vovf[2] = 1'b0;
    vin[3] = 32'd100000000;  vbcd[3] = 40'h0100000000; ven[3] = 8'hFF; vovf[3] = 1'b1;
    vin[4] = 32'd4294967295; vbcd[4] = 40'h4294967295; ven[4] = 8'hFF; vovf[4] = 1'b1;
    vin[5] = 32'd10;         vbcd[5] = 40'h0000000010; ven[5] = 8'h03; vovf[5] = 1'b0;
    for (int t = 0; t < 6; t++) begin
      bin_in = vin[t];
      start  = 1'b1;
      lat    = 0;
      do begin
        tick();
        lat++;
        start  = 1'b0;
        bin_in = 32'hDEAD_BEEF;
      end while (done !== 1'b1 && lat < 100);
      vectors++; if (lat !== 33) begin miscompares++; $display("FAIL conv%0d_latency: got %0d expected 33", t, lat); end
      vectors++; if (bcd_out !== vbcd[t]) begin miscompares++; $display("FAIL conv%0d_bcd: got %h expected %h", t, bcd_out, vbcd[t]); end
      vectors++; if (digit_en !== ven[t]) begin miscompares++; $display("FAIL conv%0d_en: got %b expected %b", t, digit_en, ven[t]); end
      vectors++; if (ovf !== vovf[t]) begin miscompares++; $display("FAIL conv%0d_ovf: got %b expected %b", t, ovf, vovf[t]); end
      tick();
      vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL conv%0d_after: got done=%b busy=%b expected 0 0", t, done, busy); end
      tick();
      tick();
      vectors++; if (bcd_out !== vbcd[t]) begin miscompares++; $display("FAIL conv%0d_hold: got %h expected %h", t, bcd_out, vbcd[t]); end
    end
  endtask

  task automatic test_ignore_start();
    int ndone;
    int done_cyc;
    int busy_bad;
    logic [39:0] got;
    ndone = 0; done_cyc = -1; busy_bad = 0; got = '0;
    bin_in = 32'd7;
    start  = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k <= 33 && busy !== 1'b1) busy_bad++;
      if (k > 33 && busy !== 1'b0) busy_bad++;
      if (done === 1'b1) begin
        ndone++;
        done_cyc = k;
        got = bcd_out;
      end
      if (k == 5) begin
        bin_in = 32'd9;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    vectors++; if (ndone !== 1) begin miscompares++; $display("FAIL ignore_ndone: got %0d expected 1", ndone); end
    vectors++; if (done_cyc !== 33) begin miscompares++; $display("FAIL ignore_cycle: got %0d expected 33", done_cyc); end
    vectors++; if (got !== 40'h7) begin miscompares++; $display("FAIL ignore_value: got %h expected 7", got); end
    vectors++; if (busy_bad !== 0) begin miscompares++; $display("FAIL ignore_busy: got %0d bad cycles expected 0", busy_bad); end
  endtask

  task automatic test_reset_abort();
    int seen;
    int lat;
    seen = 0;
    bin_in = 32'd123;
    start  = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (done === 1'b1) seen++;
      start = 1'b0;
      reset = (k == 10) ? 1'b0 : 1'b1;
    end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL abort_done: got %0d pulses expected 0", seen); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", busy); end
    vectors++; if (bcd_out !== 40'h0) begin miscompares++; $display("FAIL abort_bcd: got %h expected 0", bcd_out); end
    vectors++; if (digit_en !== 8'h01) begin miscompares++; $display("FAIL abort_en: got %b expected 00000001", digit_en); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL abort_ovf: got %b expected 0", ovf); end
    reset  = 1'b1;
    start  = 1'b1;
    bin_in = 32'd42;
    lat    = 0;
    do begin
      tick();
      lat++;
      start = 1'b0;
    end while (done !== 1'b1 && lat < 100);
    vectors++; if (lat !== 33) begin miscompares++; $display("FAIL restart_latency: got %0d expected 33", lat); end
    vectors++; if (bcd_out !== 40'h42) begin miscompares++; $display("FAIL restart_bcd: got %h expected 42", bcd_out); end
    vectors++; if (digit_en !== 8'h03) begin miscompares++; $display("FAIL restart_en: got %b expected 00000011", digit_en); end
  endtask

  task automatic test_back_to_back();
    int d1, d2, n;
    logic [39:0] v1, v2;
    d1 = -1; d2 = -1; n = 0; v1 = '0; v2 = '0;
    tick();
    bin_in = 32'd5;
    start  = 1'b1;
    for (int k = 1; k <= 100 && n < 2; k++) begin
      tick();
      if (done === 1'b1) begin
        if (n == 0) begin
          d1 = k; v1 = bcd_out; bin_in = 32'd6;
        end else begin
          d2 = k; v2 = bcd_out; start = 1'b0;
        end
        n++;
      end
    end
    start = 1'b0;
    vectors++; if (d1 !== 33) begin miscompares++; $display("FAIL b2b_first_cycle: got %0d expected 33", d1); end
    vectors++; if (d2 - d1 !== 34) begin miscompares++; $display("FAIL b2b_period: got %0d expected 34", d2 - d1); end
    vectors++; if (v1 !== 40'h5) begin miscompares++; $display("FAIL b2b_first_value: got %h expected 5", v1); end
    vectors++; if (v2 !== 40'h6) begin miscompares++; $display("FAIL b2b_second_value: got %h expected 6", v2); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    test_reset();
    test_conversions();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: binary operand width in bits.
REQ-002 SHALL have parameter NDIG, default 10: BCD digit count (10 covers 2^32-1).
REQ-003 SHALL have parameter NDISP, default 8: displayed digits (seven-segment positions ss0..ss7).
REQ-004 SHALL have port hz100  input  1: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-low reset, sampled on rising hz100.
REQ-006 SHALL have port start  input  1: one-cycle request to convert bin_in.
REQ-007 SHALL have port bin_in  input  WIDTH: unsigned binary value, e.g. calculator operand/result register.
REQ-008 SHALL have port busy  output  1: high while a conversion is in progress.
REQ-009 SHALL have port done  output  1: one-cycle pulse when new outputs become valid.
REQ-010 SHALL have port bcd_out  output  4*NDIG: packed BCD; digit i in bits [4i+3:4i], digit 0 = units.
REQ-011 SHALL have port digit_en  output  NDISP: leading-zero-blanking enables per displayed digit, feeding the seven-segment decoder enables.
REQ-012 SHALL have port ovf  output  1: high when any digit at index >= NDISP is nonzero.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-014 SHALL, in IDLE with start=1, latch bin_in into a shift register, clear the BCD scratch, load the bit counter with WIDTH, and go to SHIFT.
REQ-015 SHALL, in IDLE with start=0, remain in IDLE with all outputs held.
REQ-016 SHALL, each SHIFT cycle, first add 3 to every scratch digit >= 5, then shift {scratch, shift register} left by one and decrement the counter.
REQ-017 SHALL go from SHIFT to DONE on the cycle the counter decrements from 1 to 0 (exactly WIDTH SHIFT cycles).
REQ-018 SHALL, in DONE, register scratch into bcd_out, update digit_en and ovf, assert done for that one cycle, and return to IDLE next cycle.
REQ-019 SHALL produce done exactly WIDTH+1 cycles after the cycle start was sampled (33 for WIDTH=32).
REQ-020 SHALL assert busy in SHIFT and DONE, deassert it in IDLE.
REQ-021 SHALL ignore start whenever state is not IDLE, with no queuing; bin_in changes during SHIFT/DONE SHALL not affect the result.
REQ-022 SHALL accept a start on the first IDLE cycle after DONE, giving a back-to-back period of WIDTH+2 cycles.
REQ-023 SHALL hold bcd_out, digit_en, ovf stable between done pulses; they change only in DONE or reset.
REQ-024 SHALL set digit_en[i]=1 iff digit i is nonzero or any digit j with i<j<NDIG is nonzero; digit_en[0] SHALL always be 1.
REQ-025 SHALL never let a scratch digit exceed 9 after any shift; result SHALL equal the exact decimal value of bin_in for all 0..2^WIDTH-1.
REQ-026 SHALL compute ovf as OR of nonzero tests on digits NDISP..NDIG-1; bcd_out still carries all NDIG digits when ovf=1.

Reset
REQ-027 SHALL, when reset=0 at a rising edge, set state IDLE, busy=0, done=0, bcd_out=0, digit_en=1 (digit 0 only), ovf=0, and clear scratch, shift register, and counter.
REQ-028 SHALL let reset override start and abort any conversion in progress without emitting done.
REQ-029 SHALL accept a start on the first edge with reset=1.

Verification
REQ-030 SHALL cover bin_in=0, start at cycle N -> done at N+33, bcd_out=0, digit_en=8'b0000_0001, ovf=0.
REQ-031 SHALL cover bin_in=12345 -> bcd_out low 20 bits = 0x12345, digit_en=8'b0001_1111, ovf=0.
REQ-032 SHALL cover bin_in=99999999 -> bcd_out=0x0099999999, digit_en=8'hFF, ovf=0; bin_in=100000000 -> ovf=1; bin_in=4294967295 -> bcd_out=0x4294967295, ovf=1.
REQ-033 SHALL cover start with 7, then start with 9 and bin_in changed to 9 at N+5 -> single done at N+33 with value 7, busy high N+1..N+33.
REQ-034 SHALL cover reset=0 at N+10 mid-conversion -> no done pulse, outputs at reset values, then start with 42 -> done 33 cycles later, bcd_out=0x42.
REQ-035 SHALL cover back-to-back starts held high continuously with 5 then 6 -> done pulses 34 cycles apart with results 5 then 6.
